output_arbiter: RTL and testbench

- Responder side of the controller request/grant handshake: arbitrates between NUM_CTLS PE-array controllers competing for the shared memory/GLB transfer path.
- Each controller asserts a request and receives a one-hot grant plus the burst length it must move.
- The arbiter counts transferred beats, ends bursts, enforces a per-owner tenure limit, and rotates ownership round-robin.

---
 rtl/output_arbiter_if.sv | 31 +++
 rtl/output_arbiter.sv | 136 +++++++++++++
 tb/tb_output_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/output_arbiter_if.sv
// Request/grant bundle between the PE-array controllers and the shared-path arbiter.
// The controllers drive the master side and the arbiter is the slave (responder).
`ifndef OUT_ARB_BURST_WIDTH
`define OUT_ARB_BURST_WIDTH 8
`endif

interface output_arbiter_if #(
  parameter int unsigned NUM_CTLS    = 4,
  parameter int unsigned BURST_WIDTH = `OUT_ARB_BURST_WIDTH
);
  localparam int unsigned IDX_WIDTH = (NUM_CTLS > 1) ? $clog2(NUM_CTLS) : 1;

  logic [NUM_CTLS-1:0]    w_req;
  logic [BURST_WIDTH-1:0] w_burst_cfg;
  logic                   w_beat;
  logic [NUM_CTLS-1:0]    r_grant;
  logic [BURST_WIDTH-1:0] r_burst;
  logic [IDX_WIDTH-1:0]   r_owner;
  logic                   r_busy;
  logic                   r_burst_done;

  modport master (
    output w_req, w_burst_cfg, w_beat,
    input  r_grant, r_burst, r_owner, r_busy, r_burst_done
  );

  modport slave (
    input  w_req, w_burst_cfg, w_beat,
    output r_grant, r_burst, r_owner, r_busy, r_burst_done
  );
endinterface

// File: rtl/output_arbiter.sv
// Round-robin arbiter for the shared memory/GLB transfer path: grants one controller at a
// time, counts beats per burst, and forces release after MAX_BURSTS back-to-back bursts.
`ifndef OUT_ARB_BURST_WIDTH
`define OUT_ARB_BURST_WIDTH 8
`endif

module output_arbiter #(
  parameter int unsigned NUM_CTLS    = 4,
  parameter int unsigned BURST_WIDTH = `OUT_ARB_BURST_WIDTH,
  parameter int unsigned MAX_BURSTS  = 4
) (
  input logic             w_clock,
  input logic             w_reset,
  output_arbiter_if.slave arb
);
  localparam int unsigned IDX_WIDTH  = (NUM_CTLS > 1) ? $clog2(NUM_CTLS) : 1;
  localparam int unsigned BCNT_WIDTH = $clog2(MAX_BURSTS + 1);

  typedef enum logic [1:0] {StIdle, StXfer, StRelease} state_e;

  state_e                  state_q, state_d;
  logic [NUM_CTLS-1:0]     grant_q, grant_d;
  logic [BURST_WIDTH-1:0]  burst_q, burst_d;
  logic [IDX_WIDTH-1:0]    owner_q, owner_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [BURST_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [BCNT_WIDTH-1:0]   burst_cnt_q, burst_cnt_d;

  logic [IDX_WIDTH-1:0]    next_idx;
  logic [IDX_WIDTH-1:0]    cand;
  logic                    found;
  logic [BURST_WIDTH-1:0]  cfg_len;

  // A zero-length burst would never complete, so it is treated as one beat.
  assign cfg_len = (arb.w_burst_cfg == '0) ? BURST_WIDTH'(1) : arb.w_burst_cfg;

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    next_idx = owner_q;
    cand     = owner_q;
    found    = 1'b0;
    for (int unsigned i = 1; i <= NUM_CTLS; i++) begin
      cand = IDX_WIDTH'((32'(owner_q) + i) % NUM_CTLS);
      if (!found && arb.w_req[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    burst_d     = burst_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (arb.w_req != '0) begin
          grant_d     = NUM_CTLS'(1) << next_idx;
          owner_d     = next_idx;
          burst_d     = cfg_len;
          beat_cnt_d  = '0;
          burst_cnt_d = BCNT_WIDTH'(1);
          busy_d      = 1'b1;
          state_d     = StXfer;
        end
      end
      StXfer: begin
        // A request drop wins over a beat on the same edge; partial beats are discarded.
        if (!arb.w_req[owner_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = StRelease;
        end else if (arb.w_beat) begin
          if (beat_cnt_q + BURST_WIDTH'(1) == burst_q) begin
            done_d = 1'b1;
            if (burst_cnt_q < BCNT_WIDTH'(MAX_BURSTS)) begin
              burst_d     = cfg_len;
              beat_cnt_d  = '0;
              burst_cnt_d = burst_cnt_q + BCNT_WIDTH'(1);
            end else begin
              grant_d = '0;
              busy_d  = 1'b0;
              state_d = StRelease;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BURST_WIDTH'(1);
          end
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      burst_q     <= '0;
      owner_q     <= IDX_WIDTH'(NUM_CTLS - 1);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_q     <= burst_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign arb.r_grant      = grant_q;
  assign arb.r_burst      = burst_q;
  assign arb.r_owner      = owner_q;
  assign arb.r_busy       = busy_q;
  assign arb.r_burst_done = done_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: one instance with MAX_BURSTS=4, one with MAX_BURSTS=1.
// Expected values are hand-derived from the request/beat timelines below.
module tb_output_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  output_arbiter_if #(.NUM_CTLS(4), .BURST_WIDTH(8)) if_a ();
  output_arbiter_if #(.NUM_CTLS(4), .BURST_WIDTH(8)) if_b ();

  output_arbiter #(.NUM_CTLS(4), .BURST_WIDTH(8), .MAX_BURSTS(4)) dut_a (
    .w_clock (clk),
    .w_reset (rst),
    .arb     (if_a)
  );

  output_arbiter #(.NUM_CTLS(4), .BURST_WIDTH(8), .MAX_BURSTS(1)) dut_b (
    .w_clock (clk),
    .w_reset (rst),
    .arb     (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    if_a.w_req = '0; if_a.w_burst_cfg = '0; if_a.w_beat = 1'b0;
    if_b.w_req = '0; if_b.w_burst_cfg = '0; if_b.w_beat = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_grant", 32'(if_a.r_grant), 32'h0);
    check("rst_burst", 32'(if_a.r_burst), 32'h0);
    check("rst_owner", 32'(if_a.r_owner), 32'h3);
    check("rst_busy",  32'(if_a.r_busy),  32'h0);
    check("rst_done",  32'(if_a.r_burst_done), 32'h0);

    // MAX_BURSTS=1, four continuous requesters, 2-beat bursts: 4-cycle rotation period.
    if_b.w_req = 4'b1111; if_b.w_burst_cfg = 8'd2; if_b.w_beat = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      tick();
      check("rr_grant", 32'(if_b.r_grant),
            ((t - 1) % 4 < 2) ? (32'h1 << (((t - 1) / 4) % 4)) : 32'h0);
      check("rr_done", 32'(if_b.r_burst_done), ((t - 1) % 4 == 2) ? 32'h1 : 32'h0);
    end
    if_b.w_req = '0; if_b.w_beat = 1'b0;

    // Basic 3-beat burst on ctl 0.
    if_a.w_req = 4'b0001; if_a.w_burst_cfg = 8'd3;
    tick();
    check("t1_grant", 32'(if_a.r_grant), 32'h1);
    check("t1_burst", 32'(if_a.r_burst), 32'h3);
    check("t1_owner", 32'(if_a.r_owner), 32'h0);
    check("t1_busy",  32'(if_a.r_busy),  32'h1);
    if_a.w_beat = 1'b1;
    tick();
    tick();
    check("t1_done_early", 32'(if_a.r_burst_done), 32'h0);
    tick();
    check("t1_done", 32'(if_a.r_burst_done), 32'h1);
    check("t1_grant_kept", 32'(if_a.r_grant), 32'h1);
    if_a.w_beat = 1'b0;
    tick();
    check("t1_done_pulse", 32'(if_a.r_burst_done), 32'h0);
    if_a.w_req = '0;
    tick();
    check("t1_rel_grant", 32'(if_a.r_grant), 32'h0);
    check("t1_rel_busy",  32'(if_a.r_busy),  32'h0);
    check("t1_rel_done",  32'(if_a.r_burst_done), 32'h0);
    tick();

    // Zero burst config clamps to one beat.
    if_a.w_req = 4'b0001; if_a.w_burst_cfg = 8'd0;
    tick();
    check("z_burst", 32'(if_a.r_burst), 32'h1);
    if_a.w_beat = 1'b1;
    tick();
    check("z_done", 32'(if_a.r_burst_done), 32'h1);
    if_a.w_req = '0; if_a.w_beat = 1'b0;
    tick();
    check("z_rel", 32'(if_a.r_grant), 32'h0);
    tick();

    // ctl 2 alone: four 5-beat bursts back to back, then forced release and regrant.
    if_a.w_req = 4'b0100; if_a.w_burst_cfg = 8'd5; if_a.w_beat = 1'b1;
    tick();
    check("m_grant0", 32'(if_a.r_grant), 32'h4);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("m_grant", 32'(if_a.r_grant), (k < 20) ? 32'h4 : 32'h0);
      check("m_done", 32'(if_a.r_burst_done), (k % 5 == 0) ? 32'h1 : 32'h0);
    end
    if_a.w_beat = 1'b0;
    tick();
    check("m_gap", 32'(if_a.r_grant), 32'h0);
    tick();
    check("m_regrant", 32'(if_a.r_grant), 32'h4);
    if_a.w_req = '0;
    tick();
    tick();

    // Abort: owner ctl 3 drops after 2 of 6 beats; ctl 0 next in rotation.
    if_a.w_req = 4'b1001; if_a.w_burst_cfg = 8'd6;
    tick();
    check("a_grant", 32'(if_a.r_grant), 32'h8);
    check("a_owner", 32'(if_a.r_owner), 32'h3);
    if_a.w_beat = 1'b1;
    tick();
    tick();
    if_a.w_req = 4'b0001;
    tick();
    check("a_drop_grant", 32'(if_a.r_grant), 32'h0);
    check("a_drop_busy",  32'(if_a.r_busy),  32'h0);
    check("a_drop_done",  32'(if_a.r_burst_done), 32'h0);
    if_a.w_beat = 1'b0;
    tick();
    check("a_gap", 32'(if_a.r_grant), 32'h0);
    tick();
    check("a_next_grant", 32'(if_a.r_grant), 32'h1);
    check("a_next_owner", 32'(if_a.r_owner), 32'h0);

    // Asynchronous reset between edges while ctl 0 holds the grant.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("ar_grant", 32'(if_a.r_grant), 32'h0);
    check("ar_busy",  32'(if_a.r_busy),  32'h0);
    check("ar_owner", 32'(if_a.r_owner), 32'h3);
    tick();
    rst = 1'b0;
    if_a.w_req = 4'b1111; if_a.w_burst_cfg = 8'd2;
    tick();
    check("ar_first", 32'(if_a.r_grant), 32'h1);
    if_a.w_req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
